// File: rtl/hamming_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : hamming_tx_arbiter_if
// Brief    : Requester handshakes, encoder hookup and serial frame outputs.
// Revision : 1.0
// ============================================================================
interface hamming_tx_arbiter_if;
    logic       req0_valid;
    logic [3:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_data;
    logic       req1_ready;
    logic [3:0] enc_data;
    logic [6:0] enc_code;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_src;
    logic       frame_done;

    // Environment side: requesters, the external encoder and the link consumer.
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, enc_code,
        input  req0_ready, req1_ready, enc_data,
        input  tx_serial, tx_busy, tx_src, frame_done
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, enc_code,
        output req0_ready, req1_ready, enc_data,
        output tx_serial, tx_busy, tx_src, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/hamming_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hamming_tx_arbiter
// Brief    : Round-robin nibble arbiter feeding a shared Hamming(7,4) encoder
//            and a start/7-bit/stop serial framer.
// Revision : 1.0
// ============================================================================
module hamming_tx_arbiter #(
    parameter int BIT_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hamming_tx_arbiter_if.slave   bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_START = 3'd2;
    localparam logic [2:0] c_DATA  = 3'd3;
    localparam logic [2:0] c_STOP  = 3'd4;

    localparam logic [7:0] c_LAST_TICK = 8'(BIT_TICKS - 1);
    localparam logic [2:0] c_MSB_BIT   = 3'd6;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    logic [3:0] r_data;
    logic [6:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_tick_cnt;
    logic       r_tx_src;
    logic       r_last_grant;
    logic       r_frame_done;

    logic       w_grant0;
    logic       w_grant1;
    logic       w_handshake;
    logic       w_tick_done;
    logic [7:0] w_tick_next;

    logic       w_ready0;
    logic       w_ready1;
    logic       w_serial;
    logic       w_busy;

    // On contention the requester that lost last time wins; a lone valid always wins.
    assign w_grant0    = bus.req0_valid & (~bus.req1_valid | r_last_grant);
    assign w_grant1    = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
    assign w_handshake = (r_state == c_IDLE) & (w_grant0 | w_grant1);
    assign w_tick_done = (r_tick_cnt == c_LAST_TICK);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_tick_next  = 8'd0;
        case (r_state)
            c_IDLE: begin
                if (w_handshake) begin
                    w_next_state = c_LOAD;
                end
            end
            c_LOAD: begin
                w_next_state = c_START;
            end
            c_START: begin
                w_tick_next = w_tick_done ? 8'd0 : r_tick_cnt + 8'd1;
                if (w_tick_done) begin
                    w_next_state = c_DATA;
                end
            end
            c_DATA: begin
                w_tick_next = w_tick_done ? 8'd0 : r_tick_cnt + 8'd1;
                if (w_tick_done && (r_bit_cnt == 3'd0)) begin
                    w_next_state = c_STOP;
                end
            end
            c_STOP: begin
                w_tick_next = w_tick_done ? 8'd0 : r_tick_cnt + 8'd1;
                if (w_tick_done) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        w_serial = 1'b1;
        w_busy   = 1'b1;
        case (r_state)
            c_IDLE: begin
                w_ready0 = w_grant0;
                w_ready1 = w_grant1;
                w_busy   = 1'b0;
            end
            c_START: begin
                w_serial = 1'b0;
            end
            c_DATA: begin
                w_serial = r_shift[6];
            end
            default: begin
                w_serial = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: capture, shift and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= 4'd0;
            r_shift      <= 7'd0;
            r_bit_cnt    <= 3'd0;
            r_tick_cnt   <= 8'd0;
            r_tx_src     <= 1'b0;
            r_last_grant <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_next;
            // Registered one cycle early so the pulse lines up with the last STOP cycle.
            r_frame_done <= (w_next_state == c_STOP) && (w_tick_next == c_LAST_TICK);

            if (w_handshake) begin
                r_data       <= w_grant1 ? bus.req1_data : bus.req0_data;
                r_tx_src     <= w_grant1;
                r_last_grant <= w_grant1;
            end

            if (r_state == c_LOAD) begin
                r_shift   <= bus.enc_code;
                r_bit_cnt <= c_MSB_BIT;
            end else if ((r_state == c_DATA) && w_tick_done) begin
                r_shift <= {r_shift[5:0], 1'b0};
                if (r_bit_cnt != 3'd0) begin
                    r_bit_cnt <= r_bit_cnt - 3'd1;
                end
            end
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.enc_data   = r_data;
    assign bus.tx_serial  = w_serial;
    assign bus.tx_busy    = w_busy;
    assign bus.tx_src     = r_tx_src;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hamming_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_tx_arbiter
// Brief    : Directed bench for two arbiter instances (BIT_TICKS 4 and 1).
// Revision : 1.0
// ============================================================================
module tb_hamming_tx_arbiter;

    logic clk;
    logic rst_n;
    logic sel;
    int   errors = 0;
    int   checks = 0;

    hamming_tx_arbiter_if bus4();
    hamming_tx_arbiter_if bus1();

    hamming_tx_arbiter #(.BIT_TICKS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    hamming_tx_arbiter #(.BIT_TICKS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Systematic Hamming(7,4): {d3..d0, p2, p1, p0}
    function automatic logic [6:0] ham(input logic [3:0] d);
        return {d, d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
    endfunction

    assign bus4.enc_code = ham(bus4.enc_data);
    assign bus1.enc_code = ham(bus1.enc_data);

    logic       m_ready0, m_ready1, m_serial, m_busy, m_src, m_done;
    logic [3:0] m_enc;
    always_comb begin
        m_ready0 = sel ? bus1.req0_ready : bus4.req0_ready;
        m_ready1 = sel ? bus1.req1_ready : bus4.req1_ready;
        m_serial = sel ? bus1.tx_serial  : bus4.tx_serial;
        m_busy   = sel ? bus1.tx_busy    : bus4.tx_busy;
        m_src    = sel ? bus1.tx_src     : bus4.tx_src;
        m_done   = sel ? bus1.frame_done : bus4.frame_done;
        m_enc    = sel ? bus1.enc_data   : bus4.enc_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int r, input logic v, input logic [3:0] d);
        if (sel == 1'b0) begin
            if (r == 0) begin bus4.req0_valid = v; bus4.req0_data = d; end
            else        begin bus4.req1_valid = v; bus4.req1_data = d; end
        end else begin
            if (r == 0) begin bus1.req0_valid = v; bus1.req0_data = d; end
            else        begin bus1.req1_valid = v; bus1.req1_data = d; end
        end
    endtask

    task automatic check_idle(input string tag, input logic src);
        chk({tag, "_serial"}, m_serial, 1);
        chk({tag, "_busy"},   m_busy,   0);
        chk({tag, "_done"},   m_done,   0);
        chk({tag, "_src"},    m_src,    src);
    endtask

    // Called at the falling edge inside LOAD; returns at the falling edge of the last STOP cycle.
    task automatic check_frame(input logic [6:0] code, input logic src, input int bt, input int poke);
        logic [8:0] fr;
        int         rdy;
        fr  = {1'b0, code, 1'b1};
        rdy = 0;
        chk("load_serial", m_serial, 1);
        chk("load_busy",   m_busy,   1);
        for (int k = 0; k < 9 * bt; k++) begin
            @(negedge clk);
            if (poke >= 0 && k == poke) begin
                drive(1, 1'b1, 4'b1010);
                #1;
                chk("withdrawn_ready1", m_ready1, 0);
            end
            if (poke >= 0 && k == poke + 1) begin
                drive(1, 1'b0, 4'b1010);
            end
            chk("frame_bit",  m_serial, fr[8 - k / bt]);
            chk("frame_done", m_done,   (k == 9 * bt - 1));
            chk("frame_busy", m_busy,   1);
            rdy += int'(m_ready0) + int'(m_ready1);
        end
        chk("frame_src",         m_src, src);
        chk("frame_ready_quiet", rdy,   0);
    endtask

    initial begin
        logic exp_src;
        sel   = 1'b0;
        rst_n = 1'b0;
        bus4.req0_valid = 1'b0; bus4.req0_data = 4'd0;
        bus4.req1_valid = 1'b0; bus4.req1_data = 4'd0;
        bus1.req0_valid = 1'b0; bus1.req0_data = 4'd0;
        bus1.req1_valid = 1'b0; bus1.req1_data = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle("rst", 1'b0);
        chk("rst_ready0", m_ready0, 0);
        chk("rst_ready1", m_ready1, 0);
        chk("rst_enc",    m_enc,    0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_rst", 1'b0);

        // Single request, BIT_TICKS=4
        drive(0, 1'b1, 4'b1011);
        #1;
        chk("single_ready0", m_ready0, 1);
        chk("single_ready1", m_ready1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 4'b0000);
        chk("single_load_ready0", m_ready0, 0);
        chk("single_enc",         m_enc,    4'b1011);
        check_frame(7'b1011001, 1'b0, 4, -1);
        @(negedge clk);
        check_idle("single_after", 1'b0);

        // Contention from a fresh reset: req0, req1, then req0 again
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 4'b0001);
        drive(1, 1'b1, 4'b0110);
        #1;
        chk("cont1_ready0", m_ready0, 1);
        chk("cont1_ready1", m_ready1, 0);
        @(posedge clk);
        @(negedge clk);
        check_frame(7'b0001011, 1'b0, 4, -1);
        @(negedge clk);
        chk("cont2_ready0", m_ready0, 0);
        chk("cont2_ready1", m_ready1, 1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 4'b0000);
        check_frame(7'b0110011, 1'b1, 4, -1);
        @(negedge clk);
        chk("cont3_ready0", m_ready0, 1);
        chk("cont3_ready1", m_ready1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 4'b0000);
        check_frame(7'b0001011, 1'b0, 4, -1);
        @(negedge clk);
        check_idle("cont_after", 1'b0);

        // Starvation check on the BIT_TICKS=1 instance
        sel = 1'b1;
        drive(0, 1'b1, 4'b0011);
        drive(1, 1'b1, 4'b1100);
        for (int f = 0; f < 6; f++) begin
            exp_src = f[0];
            #1;
            chk("starve_ready0", m_ready0, !exp_src);
            chk("starve_ready1", m_ready1, exp_src);
            @(posedge clk);
            @(negedge clk);
            check_frame(exp_src ? 7'b1100001 : 7'b0011110, exp_src, 1, -1);
            @(negedge clk);
        end

        // Back-to-back on requester 1, BIT_TICKS=1
        drive(0, 1'b0, 4'b0000);
        drive(1, 1'b1, 4'b1111);
        #1;
        chk("b2b1_ready1", m_ready1, 1);
        chk("b2b1_ready0", m_ready0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b1_enc", m_enc, 4'b1111);
        drive(1, 1'b1, 4'b0000);
        check_frame(7'b1111111, 1'b1, 1, -1);
        @(negedge clk);
        chk("b2b_gap_serial", m_serial, 1);
        chk("b2b_gap_busy",   m_busy,   0);
        chk("b2b2_ready1",    m_ready1, 1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 4'b0000);
        chk("b2b2_enc", m_enc, 4'b0000);
        check_frame(7'b0000000, 1'b1, 1, -1);
        @(negedge clk);
        check_idle("b2b_after", 1'b1);

        // Reset during code bit 3 on the BIT_TICKS=4 instance
        sel = 1'b0;
        drive(0, 1'b1, 4'b0110);
        #1;
        chk("rstmid_ready0", m_ready0, 1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 4'b0000);
        repeat (18) @(negedge clk);
        chk("rstmid_bit3",  m_serial, 0);
        chk("rstmid_busy",  m_busy,   1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_async_serial", m_serial, 1);
        chk("rstmid_async_busy",   m_busy,   0);
        chk("rstmid_async_done",   m_done,   0);
        @(negedge clk);
        chk("rstmid_hold_done", m_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rstmid_release", 1'b0);
        drive(1, 1'b1, 4'b1011);
        #1;
        chk("rstmid_req1_ready", m_ready1, 1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 4'b0000);
        check_frame(7'b1011001, 1'b1, 4, -1);
        @(negedge clk);
        check_idle("rstmid_after", 1'b1);

        // Valid withdrawn while a frame is in flight
        drive(0, 1'b1, 4'b0001);
        #1;
        chk("wd_ready0", m_ready0, 1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 4'b0000);
        check_frame(7'b0001011, 1'b0, 4, 5);
        @(negedge clk);
        chk("wd_idle_ready1", m_ready1, 0);
        check_idle("wd_idle", 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("wd_no_frame_busy", m_busy, 0);
            chk("wd_src_kept",      m_src,  0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
